// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_bus_arbiter                                               |
// | Purpose  : Round-robin fetch/data arbiter for one 16-bit bus             |
// |            with RAM / I-O region decode and per-region wait states.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mem_bus_arbiter #(
   parameter int unsigned RAM_WAIT = 0,
   parameter int unsigned IO_WAIT  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic [15:0] if_rdata,
   output logic        if_ack,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic [15:0] d_rdata,
   output logic        d_ack,
   output logic [15:0] bus_addr,
   output logic [15:0] bus_wdata,
   output logic        bus_we,
   output logic [1:0]  bus_sel,
   input  logic [15:0] bus_rdata
);

   localparam logic [1:0] c_IDLE     = 2'd0;
   localparam logic [1:0] c_ACCESS   = 2'd1;
   localparam logic [1:0] c_ACK      = 2'd2;

   localparam logic [1:0] c_SEL_IDLE = 2'b00;
   localparam logic [1:0] c_SEL_RAM  = 2'b01;
   localparam logic [1:0] c_SEL_IO   = 2'b10;

   localparam logic       c_PORT_FETCH = 1'b0;
   localparam logic       c_PORT_DATA  = 1'b1;

   localparam logic [3:0] c_RAM_WAIT = 4'(RAM_WAIT);
   localparam logic [3:0] c_IO_WAIT  = 4'(IO_WAIT);

   logic [1:0]  r_state;
   logic [1:0]  w_next_state;
   logic [3:0]  r_cnt;
   logic        r_last_grant;
   logic        r_owner;

   logic        w_grant;
   logic        w_grant_data;
   logic [15:0] w_grant_addr;
   logic        w_is_io;
   logic        w_complete;
   logic        w_is_read;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_grant) begin
               w_next_state = c_ACCESS;
            end
         end
         c_ACCESS: begin
            if (w_complete) begin
               w_next_state = c_ACK;
            end
         end
         c_ACK: begin
            w_next_state = c_IDLE;
         end
         default: begin
            w_next_state = c_IDLE;
         end
      endcase
   end

   // Decode / arbitration: on a tie the port that did not win last time gets the bus
   always_comb begin
      w_grant      = (r_state == c_IDLE) && (if_req || d_req);
      w_grant_data = d_req && (!if_req || (r_last_grant == c_PORT_FETCH));
      w_grant_addr = w_grant_data ? d_addr : if_addr;
      w_is_io      = (w_grant_addr[15:13] == 3'b111);
      w_complete   = (r_state == c_ACCESS) && (r_cnt == 4'd0);
      w_is_read    = !bus_we;
   end

   // Bus, counter and response registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt        <= 4'd0;
         r_last_grant <= c_PORT_FETCH;
         r_owner      <= c_PORT_FETCH;
         bus_addr     <= 16'h0000;
         bus_wdata    <= 16'h0000;
         bus_we       <= 1'b0;
         bus_sel      <= c_SEL_IDLE;
         if_rdata     <= 16'h0000;
         d_rdata      <= 16'h0000;
         if_ack       <= 1'b0;
         d_ack        <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_grant) begin
                  bus_addr     <= w_grant_addr;
                  bus_wdata    <= d_wdata;
                  bus_we       <= w_grant_data & d_we;
                  bus_sel      <= w_is_io ? c_SEL_IO : c_SEL_RAM;
                  r_cnt        <= w_is_io ? c_IO_WAIT : c_RAM_WAIT;
                  r_last_grant <= w_grant_data;
                  r_owner      <= w_grant_data;
               end
            end
            c_ACCESS: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  if (r_owner == c_PORT_DATA) begin
                     d_ack <= 1'b1;
                     if (w_is_read) begin
                        d_rdata <= bus_rdata;
                     end
                  end else begin
                     if_ack   <= 1'b1;
                     if_rdata <= bus_rdata;
                  end
                  bus_sel <= c_SEL_IDLE;
                  bus_we  <= 1'b0;
               end
            end
            c_ACK: begin
               if_ack <= 1'b0;
               d_ack  <= 1'b0;
            end
            default: begin
               if_ack  <= 1'b0;
               d_ack   <= 1'b0;
               bus_sel <= c_SEL_IDLE;
               bus_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mem_bus_arbiter                                            |
// | Purpose  : Scoreboard bench for mem_bus_arbiter (default wait states).   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we;
   logic [15:0] if_addr, d_addr, d_wdata;
   logic [15:0] if_rdata, d_rdata, bus_addr, bus_wdata, bus_rdata;
   logic        if_ack, d_ack, bus_we;
   logic [1:0]  bus_sel;
   logic [15:0] key;

   // Target model: read data is a keyed function of the bus address
   assign bus_rdata = bus_addr ^ key;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.RAM_WAIT(0), .IO_WAIT(2)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
      .bus_sel(bus_sel), .bus_rdata(bus_rdata)
   );

   typedef struct {
      bit          port;    // 1 = data, 0 = fetch
      logic [15:0] rdata;
      int          cyc;     // negedge index at which the ack must be seen
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] m_d_rdata = 16'h0000;
   logic [15:0] m_if_rdata = 16'h0000;
   logic [1:0]  sel_h [0:63];
   logic        we_h  [0:63];
   logic [15:0] wd_h  [0:63];
   logic [15:0] ad_h  [0:63];

   function automatic void push_read(input bit port, input logic [15:0] addr, input int cyc);
      exp_t e;
      e.port  = port;
      e.rdata = addr ^ key;
      e.cyc   = cyc;
      if (port) m_d_rdata = e.rdata;
      else      m_if_rdata = e.rdata;
      exp_q.push_back(e);
   endfunction

   function automatic void push_write(input int cyc);
      exp_t e;
      e.port  = 1'b1;
      e.rdata = m_d_rdata;
      e.cyc   = cyc;
      exp_q.push_back(e);
   endfunction

   // Runs from the negedge where requests were driven until every queued ack is seen
   task automatic run_mon(input int max);
      int          cyc = 0;
      exp_t        e;
      logic [15:0] got;
      while (exp_q.size() != 0 && cyc < max) begin
         @(negedge clk);
         cyc++;
         if (cyc < 64) begin
            sel_h[cyc] = bus_sel;
            we_h[cyc]  = bus_we;
            wd_h[cyc]  = bus_wdata;
            ad_h[cyc]  = bus_addr;
         end
         checks++;
         if ((if_ack && d_ack) || bus_sel == 2'b11) begin
            errors++;
            $display("FAIL exclusive: if_ack=%b d_ack=%b bus_sel=%b", if_ack, d_ack, bus_sel);
         end
         if (if_ack || d_ack) begin
            e = exp_q.pop_front();
            checks++;
            if (d_ack !== e.port || cyc !== e.cyc) begin
               errors++;
               $display("FAIL ack_timing: got port=%0d cycle=%0d, expected port=%0d cycle=%0d",
                        d_ack, cyc, e.port, e.cyc);
            end
            got = e.port ? d_rdata : if_rdata;
            checks++;
            if (got !== e.rdata) begin
               errors++;
               $display("FAIL rdata: got %h expected %h (port %0d)", got, e.rdata, e.port);
            end
            if (d_ack) d_req = 1'b0;
            else       if_req = 1'b0;
         end
      end
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL timeout: %0d acks outstanding after %0d cycles", exp_q.size(), max);
         exp_q.delete();
         if_req = 1'b0;
         d_req  = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (if_ack !== 1'b0 || d_ack !== 1'b0) begin
         errors++;
         $display("FAIL ack_width: if_ack=%b d_ack=%b expected 0 0", if_ack, d_ack);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      if_req = 0; d_req = 0; d_we = 0;
      if_addr = '0; d_addr = '0; d_wdata = '0; key = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({if_rdata, d_rdata, bus_addr, bus_wdata, bus_we, bus_sel, if_ack, d_ack} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: bus_sel=%b bus_addr=%h acks=%b%b expected all 0",
                  bus_sel, bus_addr, if_ack, d_ack);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ram_read;
      key = 16'hBEFF;
      d_we = 0; d_addr = 16'h0010; d_req = 1;
      push_read(1'b1, 16'h0010, 2);
      run_mon(20);
      checks++;
      if (sel_h[1] !== 2'b01) begin
         errors++;
         $display("FAIL ram_sel: got %b expected 01", sel_h[1]);
      end
      checks++;
      if (d_rdata !== 16'hBEEF || if_rdata !== 16'h0000) begin
         errors++;
         $display("FAIL ram_rdata: d_rdata=%h if_rdata=%h expected BEEF 0000", d_rdata, if_rdata);
      end
   endtask

   task automatic test_io_read;
      key = 16'h1357;
      if_addr = 16'hE004; if_req = 1;
      push_read(1'b0, 16'hE004, 4);
      run_mon(20);
      checks++;
      if (sel_h[1] !== 2'b10 || sel_h[2] !== 2'b10 || sel_h[3] !== 2'b10 || sel_h[4] !== 2'b00) begin
         errors++;
         $display("FAIL io_sel: got %b %b %b %b expected 10 10 10 00",
                  sel_h[1], sel_h[2], sel_h[3], sel_h[4]);
      end
   endtask

   task automatic test_tie_data_first;
      key = 16'h0F0F;
      d_we = 0; d_addr = 16'h0200; if_addr = 16'h0100;
      d_req = 1; if_req = 1;
      push_read(1'b1, 16'h0200, 2);
      push_read(1'b0, 16'h0100, 5);
      run_mon(30);
      checks++;
      if (sel_h[3] !== 2'b00 || sel_h[4] !== 2'b01 || ad_h[4] !== 16'h0100) begin
         errors++;
         $display("FAIL tie_gap: sel3=%b sel4=%b addr4=%h expected 00 01 0100",
                  sel_h[3], sel_h[4], ad_h[4]);
      end
   endtask

   task automatic test_write;
      d_we = 1; d_addr = 16'h1234; d_wdata = 16'h5A5A; d_req = 1;
      push_write(2);
      run_mon(20);
      d_we = 0;
      checks++;
      if (we_h[1] !== 1'b1 || wd_h[1] !== 16'h5A5A || sel_h[1] !== 2'b01 || ad_h[1] !== 16'h1234) begin
         errors++;
         $display("FAIL write_bus: we=%b wdata=%h sel=%b addr=%h expected 1 5A5A 01 1234",
                  we_h[1], wd_h[1], sel_h[1], ad_h[1]);
      end
      checks++;
      if (we_h[2] !== 1'b0 || sel_h[2] !== 2'b00) begin
         errors++;
         $display("FAIL write_release: we=%b sel=%b expected 0 00", we_h[2], sel_h[2]);
      end
   endtask

   task automatic test_tie_fetch_first;
      key = 16'h3C3C;
      d_we = 0; d_addr = 16'h0042; if_addr = 16'h0084;
      d_req = 1; if_req = 1;
      push_read(1'b0, 16'h0084, 2);
      push_read(1'b1, 16'h0042, 5);
      run_mon(30);
      checks++;
      if (ad_h[1] !== 16'h0084 || ad_h[4] !== 16'h0042) begin
         errors++;
         $display("FAIL tie2_order: addr1=%h addr4=%h expected 0084 0042", ad_h[1], ad_h[4]);
      end
   endtask

   task automatic test_boundary;
      key = 16'h6A6A;
      d_we = 0; d_addr = 16'hDFFF; d_req = 1;
      push_read(1'b1, 16'hDFFF, 2);
      run_mon(20);
      checks++;
      if (sel_h[1] !== 2'b01) begin
         errors++;
         $display("FAIL bound_dfff: sel=%b expected 01", sel_h[1]);
      end
      d_addr = 16'hE000; d_req = 1;
      push_read(1'b1, 16'hE000, 4);
      run_mon(20);
      checks++;
      if (sel_h[1] !== 2'b10) begin
         errors++;
         $display("FAIL bound_e000: sel=%b expected 10", sel_h[1]);
      end
   endtask

   task automatic test_reset_abort;
      key = 16'h2468;
      if_addr = 16'hE008; if_req = 1;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({if_rdata, d_rdata, bus_addr, bus_wdata, bus_we, bus_sel, if_ack, d_ack} !== '0) begin
         errors++;
         $display("FAIL async_reset: bus_sel=%b bus_addr=%h if_rdata=%h expected all 0",
                  bus_sel, bus_addr, if_rdata);
      end
      @(negedge clk);
      checks++;
      if (if_ack !== 1'b0 || d_ack !== 1'b0 || bus_sel !== 2'b00) begin
         errors++;
         $display("FAIL reset_hold: acks=%b%b sel=%b expected 00 00", if_ack, d_ack, bus_sel);
      end
      rst = 1'b0;
      m_d_rdata  = 16'h0000;
      m_if_rdata = 16'h0000;
      push_read(1'b0, 16'hE008, 4);
      run_mon(20);
      checks++;
      if (d_rdata !== m_d_rdata) begin
         errors++;
         $display("FAIL reset_d_rdata: got %h expected %h", d_rdata, m_d_rdata);
      end
   endtask

   initial begin
      test_reset();
      test_ram_read();
      test_io_read();
      test_tie_data_first();
      test_write();
      test_tie_fetch_first();
      test_boundary();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 16-bit memory/I-O bus between the instruction-fetch port and the data (load/store) port.
- Decodes the target region from the address: addr[15:13]==3'b111 selects I/O; everything else selects RAM.
- Drives a registered one-hot bus select and inserts a per-region number of wait states.
- Returns read data and a one-cycle ack to the requester that won arbitration.

Parameters:
- RAM_WAIT, 0, extra wait cycles for a RAM access (0..15)
- IO_WAIT, 2, extra wait cycles for an I/O access (0..15)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- if_req  input  1  fetch request; held high until if_ack
- if_addr  input  16  fetch address
- if_rdata  output  16  fetch read data, registered
- if_ack  output  1  one-cycle completion pulse for fetch
- d_req  input  1  data request; held high until d_ack
- d_we  input  1  1 = write, 0 = read
- d_addr  input  16  data address
- d_wdata  input  16  write data
- d_rdata  output  16  data read data, registered
- d_ack  output  1  one-cycle completion pulse for data
- bus_addr  output  16  registered bus address
- bus_wdata  output  16  registered bus write data
- bus_we  output  1  registered bus write strobe
- bus_sel  output  2  2'b01 RAM, 2'b10 I/O, 2'b00 idle
- bus_rdata  input  16  read data from the selected target

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, all outputs 0, wait counter 0, last_grant=FETCH.
  - A reset asserted mid-access aborts the access immediately: bus_sel=00, no ack is issued.
- State IDLE, at a clock edge:
  - If neither request is high, remain in IDLE.
  - Arbitration for a grant:
    - Only one request high: grant it.
    - Both high: grant the port not in last_grant (round-robin). After reset, data wins the first tie.
  - On grant:
    - Register bus_addr from the granted port's address.
    - bus_we = d_we for a data grant, 0 for a fetch grant.
    - Register bus_wdata from d_wdata.
    - bus_sel = 2'b10 if addr[15:13]==3'b111, else 2'b01.
    - Load cnt = IO_WAIT or RAM_WAIT according to region.
    - Update last_grant and go to ACCESS.
- State ACCESS:
  - cnt!=0: decrement cnt; bus_* stay stable.
  - cnt==0, completing the access:
    - For a read, capture bus_rdata into the granted port's rdata register. A write leaves d_rdata unchanged.
    - Assert the granted port's ack for exactly the next cycle.
    - Clear bus_sel to 00 and bus_we to 0. bus_addr/bus_wdata hold their last value.
    - Go to ACK.
- State ACK:
  - Deassert ack at the next edge and return to IDLE; no grant is made in ACK.
  - This guarantees the requester has dropped req before re-arbitration.
  - Earliest back-to-back grant is the edge after ACK.
- Latency, from the edge that samples req in IDLE:
  - bus_sel valid 1 cycle later.
  - ack high (2 + wait) cycles later: RAM default 2, I/O default 4.
  - rdata is valid in the same cycle ack is high and holds until the next read completes for that port.
- Request dropped mid-access: the access still completes and the ack pulse is still issued; the requester ignores it.
- if_ack and d_ack are never high together. bus_sel is never 2'b11.
- Address 16'hE000 is I/O; 16'hDFFF is RAM.

Test Plan:
- Reset, then hold d_req=1, d_we=0, d_addr=16'h0010, with bus_rdata=16'hBEEF from the cycle after grant.
  → bus_sel=01 one cycle after the sampling edge; d_ack high exactly 2 cycles after it; d_rdata=16'hBEEF; if_ack stays 0.
- if_req=1 with if_addr=16'hE004, IO_WAIT=2.
  → bus_sel=10 held for 3 cycles; if_ack high 4 cycles after the sampling edge; if_rdata equals bus_rdata at the completing edge.
- if_req and d_req both high right after reset, each held until its ack.
  → data served first, fetch second, with bus_sel=00 for at least the ACK cycle between them. A second tie then grants fetch first.
- Data write: d_we=1, d_addr=16'h1234, d_wdata=16'h5A5A.
  → bus_we=1, bus_wdata=16'h5A5A, bus_sel=01 during ACCESS; d_rdata unchanged after d_ack.
- Boundary decode: read at 16'hDFFF, then read at 16'hE000.
  → bus_sel=01, then 10; acks at 2 and 4 cycles after their respective sampling edges.
- Assert rst for 1 cycle while in ACCESS of an I/O read.
  → all outputs 0 immediately (asynchronously), no ack; a request held after reset is re-granted and completes normally.
